mux4to1: RTL and testbench

Single-bit 4:1 multiplexer block that computes out = in[sel] three independent ways: a structural 2:1-mux tree, an if/else chain, and a case statement. The three results are compared every cycle to cross-check the implementations. The block also provides a registered copy of the selected bit and a sticky mismatch flag. It sits in the practice/verification datapath as a golden selector whose equivalence is self-checked in hardware.

---
 rtl/mux4to1.sv | 82 ++++++++
 tb/tb_mux4to1.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux4to1.sv
// Single-bit 4:1 selector built three independent ways (2:1-mux tree, if chain, case)
// with a registered copy of the selected bit and a sticky disagreement flag.

module mux4to1_mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? b : a;

endmodule

module mux4to1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] sel,
  input  logic [3:0] in,
  output logic       out_inst,
  output logic       out_if,
  output logic       out_case,
  output logic       out_q,
  output logic       err
);

  logic lo;
  logic hi;
  logic mismatch;
  logic out_q_d, out_q_q;
  logic err_d, err_q;

  // Structural path: sel[0] picks within each pair, sel[1] picks the pair.
  mux4to1_mux2 u_lo  (.a(in[0]), .b(in[1]), .s(sel[0]), .y(lo));
  mux4to1_mux2 u_hi  (.a(in[2]), .b(in[3]), .s(sel[0]), .y(hi));
  mux4to1_mux2 u_top (.a(lo),    .b(hi),    .s(sel[1]), .y(out_inst));

  // NOTE: every branch assigns out_if, including the final else, so no latch is inferred.
  always_comb begin
    if (sel == 2'd0)      out_if = in[0];
    else if (sel == 2'd1) out_if = in[1];
    else if (sel == 2'd2) out_if = in[2];
    else                  out_if = in[3];
  end

  // Default catches X/Z on sel and forces a known 0.
  always_comb begin
    case (sel)
      2'd0:    out_case = in[0];
      2'd1:    out_case = in[1];
      2'd2:    out_case = in[2];
      2'd3:    out_case = in[3];
      default: out_case = 1'b0;
    endcase
  end

  // Compare the driven outputs themselves so any divergence at the pins is caught.
  assign mismatch = (out_inst != out_if) || (out_if != out_case);

  always_comb begin
    out_q_d = out_q_q;
    err_d   = err_q;
    if (en)       out_q_d = out_case;
    if (mismatch) err_d   = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q_q <= out_q_d;
      err_q   <= err_d;
    end
  end

  assign out_q = out_q_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mux4to1.sv
// Directed self-checking bench for mux4to1: expectations are queued when stimulus
// is driven and popped when the corresponding DUT output is sampled.

module tb_mux4to1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] sel;
  logic [3:0] in;
  logic       out_inst;
  logic       out_if;
  logic       out_case;
  logic       out_q;
  logic       err;

  typedef struct {
    string tag;
    logic  exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_compared;
  int        n_mismatched;

  mux4to1 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sel      (sel),
    .in       (in),
    .out_inst (out_inst),
    .out_if   (out_if),
    .out_case (out_case),
    .out_q    (out_q),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_bit(input string tag, input logic exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic obs);
    sb_entry_t e;
    n_compared++;
    if (sb_q.size() == 0) begin
      n_mismatched++;
      $error("FAIL scoreboard_empty observed=%b required=<queued entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_mismatched++;
        $error("FAIL %s observed=%b required=%b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  // Directed vector table: sel, in, expected out_q after one en=1 edge.
  logic [1:0] dv_sel [6] = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd1, 2'd2};
  logic [3:0] dv_in  [6] = '{4'b1000, 4'b1001, 4'b0110, 4'b1111, 4'b1010, 4'b0100};
  logic       dv_exp [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [3:0] iv;
    n_compared   = 0;
    n_mismatched = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 2'd2;
    in    = 4'b0100;

    // Reset state and combinational outputs live during reset.
    #2;
    expect_bit("reset_out_q", 1'b0);      check(out_q);
    expect_bit("reset_err", 1'b0);        check(err);
    expect_bit("reset_out_case", 1'b1);   check(out_case);
    expect_bit("reset_out_inst", 1'b1);   check(out_inst);

    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep, one combination per cycle so err samples every one.
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      sel = k[5:4];
      in  = k[3:0];
      iv  = k[3:0];
      #1;
      expect_bit("sweep_out_inst", iv[k[5:4]]); check(out_inst);
      expect_bit("sweep_out_if",   iv[k[5:4]]); check(out_if);
      expect_bit("sweep_out_case", iv[k[5:4]]); check(out_case);
    end
    edge_then_sample();
    expect_bit("sweep_err", 1'b0);   check(err);
    expect_bit("sweep_out_q", 1'b0); check(out_q);

    // Directed capture vectors.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sel = dv_sel[k];
      in  = dv_in[k];
      en  = 1'b1;
      expect_bit($sformatf("directed_%0d_out_q", k), dv_exp[k]);
      edge_then_sample();
      check(out_q);
    end

    // Hold: out_q keeps 1 while en is low and the selected bit drops.
    @(negedge clk);
    sel = 2'd0;
    in  = 4'b0001;
    en  = 1'b1;
    expect_bit("hold_load", 1'b1);
    edge_then_sample();
    check(out_q);
    @(negedge clk);
    en = 1'b0;
    in = 4'b0000;
    #1;
    expect_bit("hold_out_case", 1'b0); check(out_case);
    for (int k = 0; k < 3; k++) begin
      expect_bit($sformatf("hold_out_q_%0d", k), 1'b1);
      edge_then_sample();
      check(out_q);
    end

    // Async reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_bit("async_out_q", 1'b0); check(out_q);
    expect_bit("async_err", 1'b0);   check(err);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    sel   = 2'd0;
    in    = 4'b0001;
    expect_bit("post_reset_out_q", 1'b1);
    edge_then_sample();
    check(out_q);

    // Clear out_q so the mismatch edge also shows a fresh capture.
    @(negedge clk);
    in = 4'b0000;
    expect_bit("pre_force_out_q", 1'b0);
    edge_then_sample();
    check(out_q);

    // Sticky error: disagreement on the same edge as an en=1 capture.
    @(negedge clk);
    sel = 2'd1;
    in  = 4'b0010;
    force dut.out_if = 1'b0;
    #1;
    expect_bit("force_err_before_edge", 1'b0); check(err);
    edge_then_sample();
    expect_bit("force_err_set", 1'b1);     check(err);
    expect_bit("force_out_q_load", 1'b1);  check(out_q);
    @(negedge clk);
    release dut.out_if;
    in = 4'b1110;
    #1;
    expect_bit("released_out_if", 1'b1); check(out_if);
    for (int k = 0; k < 2; k++) begin
      expect_bit($sformatf("sticky_err_%0d", k), 1'b1);
      edge_then_sample();
      check(err);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_bit("sticky_cleared", 1'b0); check(err);
    @(negedge clk);
    rst_n = 1'b1;
    expect_bit("err_stays_clear", 1'b0);
    edge_then_sample();
    check(err);

    if (sb_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
